// File: rtl/fft_agu_if.sv
// Beat stream from the FFT address generator towards twiddle_rom and the butterfly datapath.
// The master modport belongs to the generator; the slave modport belongs to the consumer.
interface fft_agu_if #(
   parameter int N_LOG2 = 4
);
   localparam int SW = $clog2(N_LOG2);

   logic              start;
   logic              out_ready;
   logic              out_valid;
   logic [N_LOG2-1:0] addr_a;
   logic [N_LOG2-1:0] addr_b;
   logic [N_LOG2-2:0] tw_addr;
   logic [SW-1:0]     stage;
   logic              last_in_stage;
   logic              last;
   logic              busy;
   logic              done;

   modport master (
      input  start, out_ready,
      output out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage, last, busy, done
   );

   modport slave (
      output start, out_ready,
      input  out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage, last, busy, done
   );
endinterface

// File: rtl/fft_agu.sv
// Address generation unit for the in-place radix-2 DIT FFT: one beat per butterfly carrying
// operand addresses A/B and the twiddle_rom address, with idle gaps between stages.
module fft_agu #(
   parameter int N         = 16,
   parameter int N_LOG2    = $clog2(N),
   parameter int STAGE_GAP = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   fft_agu_if.master bus
);
   localparam int KW = N_LOG2 - 1;
   localparam int SW = $clog2(N_LOG2);
   localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [KW-1:0]   k_q, k_d;
   logic [3:0]      gap_q, gap_d;

   logic              vld_q, vld_d;
   logic [N_LOG2-1:0] a_q, a_d;
   logic [N_LOG2-1:0] b_q, b_d;
   logic [KW-1:0]     tw_q, tw_d;
   logic              lis_q, lis_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [N_LOG2-1:0] kx, span, pos;

   // out_valid is high exactly in RUN, so a transfer there is simply out_ready.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: if (bus.start) begin
            state_d = RUN;
            s_d     = '0;
            k_d     = '0;
         end
         RUN: if (bus.out_ready) begin
            if (k_q != K_LAST) begin
               k_d = k_q + 1'b1;
            end else if (s_q != S_LAST) begin
               k_d = '0;
               s_d = s_q + 1'b1;
               if (STAGE_GAP > 0) begin
                  state_d = GAP;
                  gap_d   = 4'(STAGE_GAP);
               end
            end else begin
               state_d = DONE;
               k_d     = '0;
               s_d     = '0;
            end
         end
         GAP: begin
            if (gap_q <= 4'd1) begin
               state_d = RUN;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from next-state so they land in registers together with the state.
   always_comb begin
      kx     = {1'b0, k_d};
      span   = {{(N_LOG2-1){1'b0}}, 1'b1} << s_d;
      pos    = kx & (span - 1'b1);
      vld_d  = (state_d == RUN);
      busy_d = (state_d == RUN) || (state_d == GAP);
      done_d = (state_d == DONE);
      a_d    = '0;
      b_d    = '0;
      tw_d   = '0;
      lis_d  = 1'b0;
      last_d = 1'b0;
      if (vld_d) begin
         a_d    = ((kx >> s_d) << (int'(s_d) + 1)) | pos;
         b_d    = a_d + span;
         tw_d   = KW'(pos << (N_LOG2 - 1 - int'(s_d)));
         lis_d  = (k_d == K_LAST);
         last_d = (k_d == K_LAST) && (s_d == S_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         k_q     <= '0;
         gap_q   <= '0;
         vld_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         tw_q    <= '0;
         lis_q   <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         vld_q   <= vld_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tw_q    <= tw_d;
         lis_q   <= lis_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.out_valid     = vld_q;
   assign bus.addr_a        = a_q;
   assign bus.addr_b        = b_q;
   assign bus.tw_addr       = tw_q;
   assign bus.stage         = s_q;
   assign bus.last_in_stage = lis_q;
   assign bus.last          = last_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
endmodule

// File: tb/tb_fft_agu.sv
// Scoreboard bench for fft_agu (N=16): expected beats are queued at start and popped on
// each accepted beat; one instance with STAGE_GAP=4 and one with STAGE_GAP=0.
module tb_fft_agu;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] tw;
      logic [1:0] s;
      logic       lis;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start, rdy, sel;
   int   n_chk = 0;
   int   n_err = 0;

   beat_t exp_q[$];
   beat_t log_q[$];

   always #5 clk = ~clk;

   fft_agu_if #(.N_LOG2(4)) b4 ();
   fft_agu_if #(.N_LOG2(4)) b0 ();

   fft_agu #(.N(16), .N_LOG2(4), .STAGE_GAP(4)) u_gap4 (.clk(clk), .rst_n(rst_n), .bus(b4.master));
   fft_agu #(.N(16), .N_LOG2(4), .STAGE_GAP(0)) u_gap0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));

   assign b4.start     = start;
   assign b4.out_ready = rdy;
   assign b0.start     = start;
   assign b0.out_ready = rdy;

   logic       o_valid, o_lis, o_last, o_busy, o_done;
   logic [3:0] o_a, o_b;
   logic [2:0] o_tw;
   logic [1:0] o_stage;

   assign o_valid = sel ? b0.out_valid     : b4.out_valid;
   assign o_a     = sel ? b0.addr_a        : b4.addr_a;
   assign o_b     = sel ? b0.addr_b        : b4.addr_b;
   assign o_tw    = sel ? b0.tw_addr       : b4.tw_addr;
   assign o_stage = sel ? b0.stage         : b4.stage;
   assign o_lis   = sel ? b0.last_in_stage : b4.last_in_stage;
   assign o_last  = sel ? b0.last          : b4.last;
   assign o_busy  = sel ? b0.busy          : b4.busy;
   assign o_done  = sel ? b0.done          : b4.done;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic beat_t cur();
      beat_t r;
      r.a = o_a; r.b = o_b; r.tw = o_tw; r.s = o_stage; r.lis = o_lis; r.last = o_last;
      return r;
   endfunction

   // Independent model: group g of width 2*span, offset p inside it, twiddle stride N/(2*span).
   task automatic push_seq();
      for (int st = 0; st < 4; st++) begin
         for (int k = 0; k < 8; k++) begin
            int span, g, p;
            beat_t e;
            span = 1 << st;
            g    = k / span;
            p    = k % span;
            e.a    = 4'(g * 2 * span + p);
            e.b    = 4'(g * 2 * span + p + span);
            e.tw   = 3'(p * (8 / span));
            e.s    = 2'(st);
            e.lis  = (k == 7);
            e.last = (k == 7) && (st == 3);
            exp_q.push_back(e);
         end
      end
   endtask

   // rmode=1 randomises out_ready; poke re-pulses start while busy.
   task automatic run_tx(input int gap, input bit rmode, input bit poke, output int dcyc);
      beat_t got, prv, e;
      int    cyc, nb, lastc;
      bit    hold, r, fin;
      exp_q.delete();
      log_q.delete();
      push_seq();
      @(negedge clk);
      start = 1'b1; rdy = 1'b1;
      cyc = 0; nb = 0; lastc = -1; hold = 1'b0; fin = 1'b0; dcyc = -1;
      while (!fin && cyc < 400) begin
         @(negedge clk);
         cyc++;
         got   = cur();
         start = poke && o_busy && ($urandom_range(0, 2) == 0);
         if (cyc == 1) chk("done_clear", int'(o_done), 0);
         if (hold) begin
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_stable", int'(got), int'(prv));
         end
         hold = 1'b0;
         if (o_done) begin
            chk("done_after_last", cyc, lastc + 1);
            chk("busy_at_done", int'(o_busy), 0);
            chk("beats_left", exp_q.size(), 0);
            dcyc = cyc;
            fin  = 1'b1;
         end else if (o_valid) begin
            chk("busy_in_run", int'(o_busy), 1);
            r   = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = r;
            if (r) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", nb + 1, 32);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", int'(got), int'(e));
                  if (!rmode) chk("beat_cyc", cyc, 1 + nb + (nb / 8) * gap);
                  log_q.push_back(got);
                  if (e.last) lastc = cyc;
                  nb++;
               end
            end else begin
               hold = 1'b1;
               prv  = got;
            end
         end else begin
            rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      chk("done_seen", int'(fin), 1);
      start = 1'b0;
      rdy   = 1'b1;
   endtask

   task automatic chk_log(input string tag, input int idx, input int a, input int b, input int tw);
      chk({tag, "_a"},  int'(log_q[idx].a),  a);
      chk({tag, "_b"},  int'(log_q[idx].b),  b);
      chk({tag, "_tw"}, int'(log_q[idx].tw), tw);
   endtask

   task automatic chk_cover();
      for (int st = 0; st < 4; st++) begin
         logic [15:0] bm;
         bm = '0;
         for (int k = 0; k < 8; k++) begin
            bm[log_q[st*8+k].a] = 1'b1;
            bm[log_q[st*8+k].b] = 1'b1;
         end
         chk($sformatf("stage%0d_cover", st), int'(bm), 16'hFFFF);
      end
   endtask

   initial begin
      int d, n;
      rst_n = 1'b0; start = 1'b0; rdy = 1'b1; sel = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_beat", int'(cur()), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full run, ready high: explicit beat values, gaps, last/done timing, coverage.
      run_tx(4, 1'b0, 1'b0, d);
      chk("done_cycle", d, 45);
      chk_log("s0k0", 0, 0, 1, 0);
      chk_log("s0k1", 1, 2, 3, 0);
      chk("s0k7_lis", int'(log_q[7].lis), 1);
      chk_log("s1k0", 8, 0, 2, 0);
      chk_log("s1k1", 9, 1, 3, 4);
      chk_log("s1k2", 10, 4, 6, 0);
      chk_log("s3k5", 29, 5, 13, 5);
      chk_cover();

      // Random backpressure.
      run_tx(4, 1'b1, 1'b0, d);
      chk_cover();

      // start re-pulsed while busy, then a restart on the cycle after done.
      run_tx(4, 1'b0, 1'b1, d);
      chk("poke_done_cycle", d, 45);
      run_tx(4, 1'b0, 1'b0, d);
      chk_log("restart_k0", 0, 0, 1, 0);

      // Asynchronous reset in the middle of stage 2.
      exp_q.delete();
      @(negedge clk);
      start = 1'b1; rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(o_valid && o_stage == 2'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_stage2", int'(o_stage), 2);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(o_valid), 0);
      chk("arst_beat", int'(cur()), 0);
      chk("arst_busy", int'(o_busy), 0);
      chk("arst_done", int'(o_done), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_no_done", int'(o_done), 0);
      end
      rst_n = 1'b1;
      run_tx(4, 1'b0, 1'b0, d);
      chk("post_rst_done_cycle", d, 45);
      chk_log("post_rst_k0", 0, 0, 1, 0);

      // No inter-stage gap.
      sel = 1'b1;
      run_tx(0, 1'b0, 1'b0, d);
      chk("gap0_done_cycle", d, 33);
      chk_log("gap0_s1k0", 8, 0, 2, 0);
      chk_cover();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
